// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the RV64 sequential datapath: sequences fetch,
// decode, execute, memory and writeback, handshaking with imem/dmem ready.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             pc_write,
  output logic             pc_src,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_retired
);

  localparam logic [2:0] S_FETCH     = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_EXECUTE   = 3'd2;
  localparam logic [2:0] S_MEMORY    = 3'd3;
  localparam logic [2:0] S_WRITEBACK = 3'd4;
  localparam logic [2:0] S_HALT      = 3'd5;

  localparam logic [2:0] C_R  = 3'd0;
  localparam logic [2:0] C_I  = 3'd1;
  localparam logic [2:0] C_LD = 3'd2;
  localparam logic [2:0] C_SD = 3'd3;
  localparam logic [2:0] C_BR = 3'd4;

  localparam int NUM_CLASS = 5;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RFUNC = 2'b10;
  localparam logic [1:0] ALU_IFUNC = 2'b11;

  // Opcode table indexed by class code, so a match index is the class itself.
  localparam logic [NUM_CLASS-1:0][6:0] OPC_TABLE = {
    7'b1100011,   // BR
    7'b0100011,   // SD
    7'b0000011,   // LD
    7'b0010011,   // I
    7'b0110011    // R
  };

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]       state_reg;
  logic [2:0]       state_next;
  logic [2:0]       class_reg;
  logic [2:0]       class_next;
  logic             illegal_reg;
  logic             illegal_next;
  logic [CNT_W-1:0] count_reg;

  logic [NUM_CLASS-1:0] opc_match;
  logic [2:0]           dec_class;
  logic                 dec_legal;

  generate
    for (genvar gi = 0; gi < NUM_CLASS; gi++) begin : g_opc_match
      assign opc_match[gi] = (opcode == OPC_TABLE[gi]);
    end
  endgenerate

  always_comb begin
    dec_class = C_R;
    for (int i = 0; i < NUM_CLASS; i++) begin
      if (opc_match[i]) begin
        dec_class = 3'(i);
      end
    end
  end

  // Only beq is implemented among the branches; other funct3 values trap.
  assign dec_legal = opc_match[C_R] | opc_match[C_I] | opc_match[C_LD] |
                     opc_match[C_SD] | (opc_match[C_BR] & (funct3 == 3'b000));

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= S_FETCH;
      class_reg   <= C_R;
      illegal_reg <= 1'b0;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      class_reg   <= class_next;
      illegal_reg <= illegal_next;
      if (pc_write) begin
        count_reg <= count_reg + CNT_ONE;
      end
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_next   = S_FETCH;
    class_next   = class_reg;
    illegal_next = illegal_reg;
    case (state_reg)
      S_FETCH: begin
        state_next = imem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        if (!dec_legal) begin
          illegal_next = 1'b1;
          state_next   = S_HALT;
        end else begin
          class_next = dec_class;
          state_next = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        case (class_reg)
          C_R, C_I:   state_next = S_WRITEBACK;
          C_LD, C_SD: state_next = S_MEMORY;
          default:    state_next = S_FETCH;
        endcase
      end
      S_MEMORY: begin
        if (!dmem_ready) begin
          state_next = S_MEMORY;
        end else if (class_reg == C_LD) begin
          state_next = S_WRITEBACK;
        end else begin
          state_next = S_FETCH;
        end
      end
      S_WRITEBACK: begin
        state_next = S_FETCH;
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      default: begin
        state_next = S_FETCH;
      end
    endcase
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    case (state_reg)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ready;
      end
      S_EXECUTE: begin
        case (class_reg)
          C_R: begin
            alu_op = ALU_RFUNC;
          end
          C_I: begin
            alu_src = 1'b1;
            alu_op  = ALU_IFUNC;
          end
          C_LD, C_SD: begin
            alu_src = 1'b1;
            alu_op  = ALU_ADD;
          end
          C_BR: begin
            alu_op   = ALU_SUB;
            pc_write = 1'b1;
            pc_src   = zero;
          end
          default: ;
        endcase
      end
      S_MEMORY: begin
        alu_src = 1'b1;
        alu_op  = ALU_ADD;
        if (class_reg == C_LD) begin
          mem_read = 1'b1;
        end else if (class_reg == C_SD) begin
          mem_write = 1'b1;
          pc_write  = dmem_ready;
        end
      end
      S_WRITEBACK: begin
        reg_write  = 1'b1;
        mem_to_reg = (class_reg == C_LD);
        pc_write   = 1'b1;
        if (class_reg == C_R) begin
          alu_op = ALU_RFUNC;
        end else if (class_reg == C_I) begin
          alu_src = 1'b1;
          alu_op  = ALU_IFUNC;
        end
      end
      default: ;
    endcase
    // Reset must silence the datapath immediately, including the fetch request.
    if (reset) begin
      imem_req   = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      alu_src    = 1'b0;
      alu_op     = ALU_ADD;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
    end
  end

  assign state         = reset ? S_FETCH : state_reg;
  assign illegal       = illegal_reg & ~reset;
  assign instr_retired = reset ? '0 : count_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: instruction sequences with
// hand-computed per-cycle state and control values, plus a CNT_W=4 wrap check.
module tb_multicycle_control;

  logic        clk;
  logic        reset;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        zero;
  logic        imem_ready;
  logic        dmem_ready;

  logic        imem_req, ir_write, mem_read, mem_write, reg_write, mem_to_reg;
  logic        alu_src, pc_write, pc_src, illegal;
  logic [1:0]  alu_op;
  logic [2:0]  state;
  logic [31:0] instr_retired;

  logic        w4_imem_req, w4_ir_write, w4_mem_read, w4_mem_write, w4_reg_write;
  logic        w4_mem_to_reg, w4_alu_src, w4_pc_write, w4_pc_src, w4_illegal;
  logic [1:0]  w4_alu_op;
  logic [2:0]  w4_state;
  logic [3:0]  w4_retired;

  int checks   = 0;
  int failures = 0;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  multicycle_control #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_src(alu_src), .alu_op(alu_op), .pc_write(pc_write), .pc_src(pc_src),
    .illegal(illegal), .state(state), .instr_retired(instr_retired)
  );

  multicycle_control #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(w4_imem_req), .ir_write(w4_ir_write), .mem_read(w4_mem_read),
    .mem_write(w4_mem_write), .reg_write(w4_reg_write), .mem_to_reg(w4_mem_to_reg),
    .alu_src(w4_alu_src), .alu_op(w4_alu_op), .pc_write(w4_pc_write), .pc_src(w4_pc_src),
    .illegal(w4_illegal), .state(w4_state), .instr_retired(w4_retired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] enables;
    return {imem_req, ir_write, mem_read, mem_write, reg_write, pc_write};
  endfunction

  // Runs one ALU-class instruction through F,D,E,WB back to FETCH unchecked.
  task automatic run_alu(input logic [6:0] opc);
    opcode = opc; funct3 = 3'b000; imem_ready = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    reset = 1'b1; opcode = OP_R; funct3 = 3'b000; zero = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0;

    // Reset values while reset is held
    #2;
    check("rst_state", state, 0);
    check("rst_imem_req", imem_req, 0);
    check("rst_retired", instr_retired, 0);
    check("rst_illegal", illegal, 0);
    @(negedge clk); reset = 1'b0; #1;
    check("rel_state", state, 0);
    check("rel_imem_req", imem_req, 1);
    check("rel_ir_write_noready", ir_write, 0);

    // addi x1,x0,10
    opcode = OP_I; imem_ready = 1'b1; #1;
    check("addi_F_ir_write", ir_write, 1);
    tick(); check("addi_D_state", state, 1);
    check("addi_D_en", enables(), 0);
    tick(); check("addi_E_state", state, 2);
    check("addi_E_alu_op", alu_op, 2'b11);
    check("addi_E_alu_src", alu_src, 1);
    check("addi_E_pc_write", pc_write, 0);
    tick(); check("addi_W_state", state, 4);
    check("addi_W_reg_write", reg_write, 1);
    check("addi_W_pc_write", pc_write, 1);
    check("addi_W_mem_to_reg", mem_to_reg, 0);
    check("addi_W_alu_op", alu_op, 2'b11);
    tick(); check("addi_F_state", state, 0);
    check("addi_retired", instr_retired, 1);
    $display("INFO addi done retired=%0d", instr_retired);

    // ld with two dmem wait cycles
    opcode = OP_LD; imem_ready = 1'b1; dmem_ready = 1'b0;
    tick(); check("ld_D_state", state, 1);
    tick(); check("ld_E_state", state, 2);
    check("ld_E_alu_op", alu_op, 2'b00);
    check("ld_E_alu_src", alu_src, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) begin
        dmem_ready = 1'b1; #1;
      end
      check("ld_M_state", state, 3);
      check("ld_M_mem_read", mem_read, 1);
      check("ld_M_mem_write", mem_write, 0);
      check("ld_M_pc_write", pc_write, 0);
    end
    tick(); dmem_ready = 1'b0; #1;
    check("ld_W_state", state, 4);
    check("ld_W_mem_to_reg", mem_to_reg, 1);
    check("ld_W_reg_write", reg_write, 1);
    check("ld_W_mem_write", mem_write, 0);
    tick(); check("ld_F_state", state, 0);
    check("ld_retired", instr_retired, 2);
    $display("INFO ld done retired=%0d", instr_retired);

    // beq taken then not taken
    opcode = OP_BR; funct3 = 3'b000; zero = 1'b1;
    tick(); tick();
    check("beq1_E_state", state, 2);
    check("beq1_E_pc_write", pc_write, 1);
    check("beq1_E_pc_src", pc_src, 1);
    check("beq1_E_alu_op", alu_op, 2'b01);
    check("beq1_E_reg_write", reg_write, 0);
    tick(); check("beq1_F_state", state, 0);
    zero = 1'b0;
    tick(); tick();
    check("beq0_E_pc_write", pc_write, 1);
    check("beq0_E_pc_src", pc_src, 0);
    check("beq0_E_reg_write", reg_write, 0);
    tick(); check("beq_retired", instr_retired, 4);
    $display("INFO beq pair done retired=%0d", instr_retired);

    // sd with zero-wait memory
    opcode = OP_SD;
    tick(); tick();
    check("sd_E_pc_write", pc_write, 0);
    dmem_ready = 1'b1;
    tick();
    check("sd_M_state", state, 3);
    check("sd_M_mem_write", mem_write, 1);
    check("sd_M_pc_write", pc_write, 1);
    check("sd_M_pc_src", pc_src, 0);
    check("sd_M_reg_write", reg_write, 0);
    tick(); dmem_ready = 1'b0;
    check("sd_F_state", state, 0);
    check("sd_retired", instr_retired, 5);
    $display("INFO sd done retired=%0d", instr_retired);

    // sd aborted by reset during a MEMORY wait
    tick(); tick(); tick();
    check("sdab_M_state", state, 3);
    check("sdab_M_mem_write", mem_write, 1);
    check("sdab_M_pc_write", pc_write, 0);
    reset = 1'b1; dmem_ready = 1'b1; #1;
    check("sdab_rst_en", enables(), 0);
    check("sdab_rst_state", state, 0);
    check("sdab_rst_retired", instr_retired, 0);
    tick();
    check("sdab_rst_held_en", enables(), 0);
    dmem_ready = 1'b0; imem_ready = 1'b0; reset = 1'b0; #1;
    check("sdab_rel_state", state, 0);
    check("sdab_rel_imem_req", imem_req, 1);
    tick();
    check("sdab_wait_state", state, 0);
    check("sdab_wait_retired", instr_retired, 0);
    $display("INFO sd abort done retired=%0d", instr_retired);

    // Illegal opcode halts; HALT ignores ready inputs
    opcode = OP_BAD; imem_ready = 1'b1;
    tick(); check("ill_D_state", state, 1);
    tick(); check("ill_H_state", state, 5);
    check("ill_H_illegal", illegal, 1);
    for (int i = 0; i < 10; i++) begin
      dmem_ready = i[0];
      tick();
      check("ill_H_en", enables(), 0);
      check("ill_H_stay", state, 5);
    end
    check("ill_retired", instr_retired, 0);
    reset = 1'b1; #1;
    check("ill_rst_illegal", illegal, 0);
    @(negedge clk); reset = 1'b0; dmem_ready = 1'b0; #1;
    check("ill_rel_state", state, 0);
    check("ill_rel_illegal", illegal, 0);

    // Branch with funct3 other than beq is illegal
    opcode = OP_BR; funct3 = 3'b001;
    tick(); tick();
    check("bne_H_state", state, 5);
    check("bne_H_illegal", illegal, 1);
    reset = 1'b1; #1;
    @(negedge clk); reset = 1'b0; funct3 = 3'b000; #1;
    $display("INFO illegal tests done illegal=%0d", illegal);

    // 17 back-to-back adds: 4-bit counter wraps 15 -> 0 -> 1
    opcode = OP_R; imem_ready = 1'b1;
    tick(); tick();
    check("add_E_alu_op", alu_op, 2'b10);
    check("add_E_alu_src", alu_src, 0);
    tick(); tick();
    check("add1_retired", instr_retired, 1);
    for (int i = 0; i < 14; i++) run_alu(OP_R);
    check("w4_at_15", w4_retired, 15);
    run_alu(OP_R);
    check("w4_wrap_0", w4_retired, 0);
    run_alu(OP_R);
    check("w4_end_1", w4_retired, 1);
    check("w32_end_17", instr_retired, 17);
    $display("INFO add x17 done w4=%0d w32=%0d", w4_retired, instr_retired);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=%0d exp=%0d", 1, 0);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
